niosii_system_ir_receiver: RTL and testbench
============================================

// Module: niosII_system_ir_receiver
// PURPOSE
//  Avalon-MM slave that samples the IR detector pin, synchronizes and glitch-filters it, and measures
//  the duration of each level. Each completed level segment is pushed as {level, width} into a FIFO.
//  Nios II software drains the FIFO and decodes frames. This block is the receive counterpart of the
//  ir_emitter output port. An optional IRQ fires on data-available or overflow.
// PARAMETERS
//  FILTER_CYCLES  8   consecutive stable samples required to accept a level change (>=1)
//  WIDTH_BITS     16  pulse-width counter width, 1..30; saturates at MAX=2^WIDTH_BITS-1
//  FIFO_DEPTH     16  entries, power of 2, 2..128
//  IDLE_LEVEL     1   filtered level of the idle (no-carrier) line
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  address     in   2   register select
//  chipselect  in   1   slave select
//  read_n      in   1   active-low read strobe
//  write_n     in   1   active-low write strobe
//  writedata   in   32  write data
//  in_port     in   1   raw IR detector input, asynchronous to clk
//  readdata    out  32  read data, combinational from address (zero read latency)
//  irq         out  1   level interrupt, registered
// BEHAVIOUR
//  Reset: sync/filter regs=IDLE_LEVEL; cnt=0; FIFO empty; overflow=0; irq_en=0; irq=0; to_done=0.
//  Input path: 2-flop synchronizer, then filter. Filtered level (lvl) flips only after the synced
//   input differs from lvl for FILTER_CYCLES consecutive cycles; shorter glitches are ignored.
//   Fixed input-to-lvl latency L = 2+FILTER_CYCLES. Widths are exact because L applies to every edge.
//  Counter: in the cycle lvl changes, push {old lvl, cnt+1 saturated} unless to_done; then cnt<=0,
//   to_done<=0. Otherwise cnt increments each cycle, saturating at MAX.
//   Net effect: a level held N cycles is reported as N (or MAX if N>MAX).
//  Timeout: when cnt reaches MAX, lvl==IDLE_LEVEL and to_done==0, push {IDLE_LEVEL,MAX} once and set
//   to_done. The edge ending that segment pushes nothing. A non-idle level longer than MAX is reported
//   at its edge as MAX.
//  Register map (address):
//   0 DATA   R: {valid[31], level[30], 0, width[WIDTH_BITS-1:0]} of FIFO head. Empty -> all 0.
//            A read (chipselect & ~read_n & address==0) pops one entry per asserted cycle.
//            A pop on empty is a no-op.
//   1 STATUS R: bit0 not_empty, bit1 overflow (sticky), bit2 lvl, bits[15:8] fill count.
//            W: writing 1 to bit1 clears overflow; other bits ignored.
//   2 IRQEN  R/W bits[1:0]: bit0 irq on not_empty, bit1 irq on overflow; upper bits read 0.
//   3        reads 0; writes ignored.
//  FIFO:
//   - push & pop same cycle: both succeed, count unchanged. This includes the full case (no overflow).
//   - push while full with no pop: entry dropped, overflow<=1.
//   - overflow set and clear in the same cycle: set wins.
//  irq <= (irq_en[0] & not_empty) | (irq_en[1] & overflow), registered (1-cycle lag).
//  Reset mid-segment: all state returns to reset values; the partial segment is discarded.
// TESTING (FILTER_CYCLES=4, WIDTH_BITS=8, FIFO_DEPTH=4, IDLE_LEVEL=1)
//  1. After reset, read STATUS -> 0x00000004; read DATA -> 0; irq=0.
//  2. in_port high, low 100 cycles, high 40, low -> DATA pops {1,*}, then 0x80000064 (lvl0, 100),
//     then 0xC0000028 (lvl1, 40).
//  3. Low glitches of 1..3 cycles on idle line -> no FIFO entry; STATUS bit2 stays 1.
//  4. 6 segments of 20 cycles, no reads -> fill=4, overflow=1; IRQEN=2 -> irq=1;
//     write STATUS 0x2 -> overflow=0, irq=0 next cycle.
//  5. Falling edge, low 30, high 400, low -> entries {0,30} and {1,255} (0xC00000FF) only.
//     No entry when the 400-cycle high ends.
//  6. FIFO full, DATA read in the same cycle as a push -> fill stays 4, overflow stays 0;
//     reset_n pulsed mid-pulse -> STATUS 0x4, FIFO empty.

Source files
------------

// File: rtl/niosii_system_ir_receiver.sv
// IR receiver: synchronizes and glitch-filters the detector pin, measures the
// duration of every filtered level and queues {level, width} records in a FIFO
// that software drains over an Avalon-MM slave port.
module niosii_system_ir_receiver #(
  parameter int FILTER_CYCLES = 8,
  parameter int WIDTH_BITS    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter bit IDLE_LEVEL    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam int EW  = WIDTH_BITS + 1;
  localparam logic [WIDTH_BITS-1:0] MAX      = '1;
  localparam logic [FCW-1:0]        FC_LAST  = FCW'(FILTER_CYCLES - 1);
  localparam logic [AW:0]           FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_IRQEN  = 2'd2,
    REG_NONE   = 2'd3
  } reg_addr_e;

  logic                  s1_q, s1_d, s2_q, s2_d;
  logic                  lvl_q, lvl_d;
  logic [FCW-1:0]        fcnt_q, fcnt_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d, cnt_sat;
  logic                  to_done_q, to_done_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;

  logic                  lvl_change, push, pop, do_write, full, not_empty;
  logic                  rd_data, wr_status, wr_irqen;
  logic [EW-1:0]         push_entry, head;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata[31:2];
  assign head         = mem_q[rd_ptr_q];
  assign not_empty    = (count_q != '0);
  assign full         = (count_q == FULL_CNT);
  assign irq          = irq_q;

  // Synchronizer and glitch filter: lvl flips only after FILTER_CYCLES
  // consecutive synced samples disagree with it.
  // NOTE: combinational blocks assign every output a default first so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    s1_d   = in_port;
    s2_d   = s1_q;
    lvl_d  = lvl_q;
    fcnt_d = '0;
    if (s2_q != lvl_q) begin
      if (fcnt_q == FC_LAST) begin
        lvl_d = ~lvl_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  assign lvl_change = (lvl_d != lvl_q);

  // Width counter: report each finished segment, or an over-long idle segment once.
  always_comb begin
    cnt_sat    = (cnt_q == MAX) ? MAX : cnt_q + WIDTH_BITS'(1);
    cnt_d      = cnt_sat;
    to_done_d  = to_done_q;
    push       = 1'b0;
    push_entry = {lvl_q, cnt_sat};
    if (lvl_change) begin
      push      = ~to_done_q;
      cnt_d     = '0;
      to_done_d = 1'b0;
    end else if ((cnt_q == MAX) && (lvl_q == IDLE_LEVEL) && !to_done_q) begin
      push      = 1'b1;
      to_done_d = 1'b1;
    end
  end

  // Bus decode, FIFO bookkeeping, control registers and interrupt.
  always_comb begin
    rd_data   = chipselect & ~read_n & (address == REG_DATA);
    wr_status = chipselect & ~write_n & (address == REG_STATUS);
    wr_irqen  = chipselect & ~write_n & (address == REG_IRQEN);
    pop       = rd_data & not_empty;
    do_write  = push & (~full | pop);
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d  = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d   = count_q + (AW + 1)'(do_write) - (AW + 1)'(pop);
    ovf_d     = ovf_q;
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_status && writedata[1]) begin
      ovf_d = 1'b0;
    end
    irq_en_d = wr_irqen ? writedata[1:0] : irq_en_q;
    irq_d    = (irq_en_q[0] & not_empty) | (irq_en_q[1] & ovf_q);
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      REG_DATA: begin
        if (not_empty) begin
          readdata[31]             = 1'b1;
          readdata[30]             = head[EW-1];
          readdata[WIDTH_BITS-1:0] = head[WIDTH_BITS-1:0];
        end
      end
      REG_STATUS: begin
        readdata[0]    = not_empty;
        readdata[1]    = ovf_q;
        readdata[2]    = lvl_q;
        readdata[15:8] = 8'(count_q);
      end
      REG_IRQEN: readdata[1:0] = irq_en_q;
      default:   readdata = '0;
    endcase
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= IDLE_LEVEL;
      s2_q      <= IDLE_LEVEL;
      lvl_q     <= IDLE_LEVEL;
      fcnt_q    <= '0;
      cnt_q     <= '0;
      to_done_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      lvl_q     <= lvl_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
      to_done_q <= to_done_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; entries are only visible through the
  // pointers and count, which are reset, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_niosii_system_ir_receiver.sv
// Bench for the IR receiver: a segment-level reference model checked against
// readdata/irq every cycle, plus directed scenarios with literal expectations.
module tb_niosii_system_ir_receiver;

  localparam int FC    = 4;
  localparam int WB    = 8;
  localparam int DEPTH = 4;
  localparam bit IDLE  = 1'b1;
  localparam int MAXW  = 255;
  localparam int LAT   = FC + 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n, in_port;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_bad    = 0;

  niosii_system_ir_receiver #(
    .FILTER_CYCLES(FC), .WIDTH_BITS(WB), .FIFO_DEPTH(DEPTH), .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Filtered level follows the raw input once the last FC samples (seen two
  // cycles late) all disagree with it; segments are measured as run lengths.
  bit         hist [FC+1];
  bit         m_lvl, m_to, m_ovf, m_irq;
  bit [1:0]   m_en;
  int         m_run;
  logic [8:0] m_q[$];
  bit         m_flip, m_push, m_pop;
  logic [8:0] m_ent;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i <= FC; i++) hist[i] = IDLE;
        m_lvl = IDLE; m_to = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
        m_en = 2'b00; m_run = 0; m_q.delete();
      end else begin
        m_irq  = (m_en[0] && m_q.size() != 0) || (m_en[1] && m_ovf);
        m_flip = 1'b1;
        for (int i = 1; i <= FC; i++) if (hist[i] == m_lvl) m_flip = 1'b0;
        m_run++;
        m_push = 1'b0;
        m_ent  = '0;
        if (m_flip) begin
          if (!m_to) begin
            m_push = 1'b1;
            m_ent  = {m_lvl, (m_run > MAXW) ? 8'hFF : 8'(m_run)};
          end
          m_run = 0;
          m_to  = 1'b0;
        end else if (m_lvl == IDLE && m_run == MAXW + 1 && !m_to) begin
          m_push = 1'b1;
          m_ent  = {IDLE, 8'hFF};
          m_to   = 1'b1;
        end
        m_pop = chipselect && !read_n && address == 2'd0 && m_q.size() != 0;
        if (m_pop) void'(m_q.pop_front());
        if (m_push) begin
          if (m_q.size() == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(m_ent);
        end else if (chipselect && !write_n && address == 2'd1 && writedata[1]) begin
          m_ovf = 1'b0;
        end
        if (chipselect && !write_n && address == 2'd2) m_en = writedata[1:0];
        if (m_flip) m_lvl = !m_lvl;
        for (int i = FC; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
      end
    end
  end

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    case (address)
      2'd0: if (m_q.size() != 0) begin
        r[31]  = 1'b1;
        r[30]  = m_q[0][8];
        r[7:0] = m_q[0][7:0];
      end
      2'd1: begin
        r[0]    = (m_q.size() != 0);
        r[1]    = m_ovf;
        r[2]    = m_lvl;
        r[15:8] = 8'(m_q.size());
      end
      2'd2: r[1:0] = m_en;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("model_readdata", readdata, exp_rd());
      check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 2'd1; writedata = '0;
  endtask

  task automatic do_reset();
    bus_idle();
    in_port = 1'b1;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
    tick(1);
    address = 2'd1;
  endtask

  task automatic rd_pop(input logic [31:0] exp, input logic [31:0] mask, input string name);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    check(name, readdata & mask, exp);
    tick(1);
    bus_idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    bus_idle();
  endtask

  task automatic irq_is(input logic exp, input string name);
    @(negedge clk);
    check(name, {31'b0, irq}, {31'b0, exp});
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bus_idle();
    in_port = 1'b1;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // 1: reset state
    peek(2'd1, 32'h0000_0004, "t1_status");
    peek(2'd0, 32'h0000_0000, "t1_data");
    irq_is(1'b0, "t1_irq");

    // 2: basic widths
    tick(30);
    in_port = 1'b0; tick(100);
    in_port = 1'b1; tick(40);
    in_port = 1'b0; tick(20);
    rd_pop(32'hC000_0000, 32'hC000_0000, "t2_first_idle");
    rd_pop(32'h8000_0064, 32'hFFFF_FFFF, "t2_low100");
    rd_pop(32'hC000_0028, 32'hFFFF_FFFF, "t2_high40");
    peek(2'd0, 32'h0000_0000, "t2_empty");

    // 3: glitches shorter than the filter are ignored; exactly FC is accepted
    do_reset();
    for (int g = 1; g <= 3; g++) begin
      in_port = 1'b0; tick(g);
      in_port = 1'b1; tick(15);
    end
    peek(2'd1, 32'h0000_0004, "t3_glitch_status");
    in_port = 1'b0; tick(FC);
    in_port = 1'b1; tick(15);
    peek(2'd1, 32'h0000_0205, "t3_min_status");
    rd_pop(32'hC000_0000, 32'hC000_0000, "t3_first_idle");
    rd_pop(32'h8000_0004, 32'hFFFF_FFFF, "t3_low4");

    // 4: overflow and interrupts
    do_reset();
    tick(10);
    for (int s = 0; s < 6; s++) begin
      in_port = (s % 2 == 0) ? 1'b0 : 1'b1;
      tick(20);
    end
    in_port = 1'b0; tick(20);
    peek(2'd1, 32'h0000_0403, "t4_overflow_status");
    irq_is(1'b0, "t4_irq_disabled");
    wr(2'd2, 32'hFFFF_FFFE);
    peek(2'd2, 32'h0000_0002, "t4_irqen_rb");
    irq_is(1'b1, "t4_irq_ovf");
    wr(2'd1, 32'h0000_0002);
    peek(2'd1, 32'h0000_0401, "t4_ovf_cleared");
    irq_is(1'b0, "t4_irq_cleared");
    wr(2'd2, 32'h0000_0001);
    tick(1);
    irq_is(1'b1, "t4_irq_not_empty");
    wr(2'd2, 32'h0000_0000);

    // 5: idle timeout reported once, no entry when the long high ends
    do_reset();
    tick(20);
    in_port = 1'b0; tick(30);
    in_port = 1'b1; tick(400);
    in_port = 1'b0; tick(20);
    peek(2'd1, 32'h0000_0301, "t5_status");
    rd_pop(32'hC000_0000, 32'hC000_0000, "t5_first_idle");
    rd_pop(32'h8000_001E, 32'hFFFF_FFFF, "t5_low30");
    rd_pop(32'hC000_00FF, 32'hFFFF_FFFF, "t5_timeout");
    peek(2'd0, 32'h0000_0000, "t5_empty");

    // 6: pop and push in the same cycle while full, then reset mid-pulse
    do_reset();
    tick(10);
    in_port = 1'b0; tick(20);
    in_port = 1'b1; tick(20);
    in_port = 1'b0; tick(20);
    in_port = 1'b1; tick(20);
    peek(2'd1, 32'h0000_0405, "t6_full");
    in_port = 1'b0; tick(LAT - 1);
    rd_pop(32'hC000_0000, 32'hC000_0000, "t6_pop_on_push");
    tick(5);
    peek(2'd1, 32'h0000_0401, "t6_after_pushpop");
    reset_n = 1'b0; tick(2);
    reset_n = 1'b1;
    peek(2'd1, 32'h0000_0004, "t6_reset_status");
    peek(2'd0, 32'h0000_0000, "t6_reset_data");
    in_port = 1'b1; tick(20);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
